// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised inter-stage pipeline register.
// DEPTH slices of {data, valid} in series between a producing stage (stall
// bit STAGE) and its consumer (stall bit STAGE+1). Supports flush/squash,
// consumer hold, bubble insertion when only the producer stalls, and
// saturating stall/bubble performance counters.
module pipe_stage_buf #(
  parameter  int DATA_W  = 137,
  parameter  int DEPTH   = 1,
  parameter  int STALL_W = 6,
  parameter  int STAGE   = 3,
  parameter  int CNT_W   = 16,
  localparam int OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               clr_cnt,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic [OCC_W-1:0]   occupancy,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  // Illegal configurations stop elaboration instead of silently misbehaving.
  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_stage_buf: DEPTH must be >= 1");
  end
  if (STAGE < 0 || STAGE + 1 >= STALL_W) begin : g_bad_stage
    $error("pipe_stage_buf: STAGE+1 must index a bit of the stall vector");
  end

  // Masks select the producer and consumer stall bits; every other bit of
  // the global vector is ANDed with zero and has no effect.
  localparam logic [STALL_W-1:0] PROD_MASK = STALL_W'(1) << STAGE;
  localparam logic [STALL_W-1:0] CONS_MASK = STALL_W'(1) << (STAGE + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  logic hold;
  logic bubble;

  // Consumer stall freezes every slice; producer-only stall injects a bubble.
  always_comb begin
    hold   = |(stall & CONS_MASK);
    bubble = |(stall & PROD_MASK) & ~hold;
  end

  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;

  // Next slice contents: flush beats hold, hold beats bubble, bubble beats advance.
  always_comb begin
    // NOTE: defaulting every output of a combinational block to its held value
    // first means no path leaves it unassigned, so no latch is inferred.
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_d[k] = '0;
      end
      valid_d = '0;
    end else if (!hold) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      if (bubble) begin
        data_d[0]  = '0;
        valid_d[0] = 1'b0;
      end else begin
        data_d[0]  = in_data;
        valid_d[0] = in_valid;
      end
    end
  end

  // Slice registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      // NOTE: the slice array is reset, not just the valid bits, because a
      // squashed or reset slice must present an all-zero NOP payload.
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d;

  // Saturating performance counters; clear wins and flush cycles count nothing.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else if (!flush && hold) begin
      if (stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else if (!flush && bubble) begin
      if (bubble_cnt_q != CNT_MAX) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  logic [OCC_W-1:0] occ;

  // Occupancy is the popcount of the registered valid bits.
  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ = occ + OCC_W'(valid_q[k]);
    end
  end

  assign out_data   = data_q[DEPTH-1];
  assign out_valid  = valid_q[DEPTH-1];
  assign occupancy  = occ;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule
